// File: rtl/sram_like_arbiter.sv
// Purpose : shares one sram-like master port among NREQ sram-like requesters,
//           one transaction in flight at a time (grant -> address -> data).
// Latency : grant registered one cycle after s_req; s_addr_ok/s_data_ok are
//           same-cycle pass-throughs of m_addr_ok/m_data_ok; one IDLE bubble
//           between transactions.
// Backpressure: m_addr_ok low holds m_req and all m_* fields stable; losers of
//           arbitration wait with s_req high and see no ack.
//
// Ports:
//   clock, resetn           clock and synchronous active-low reset
//   s_req/s_wr/s_size/...   per-requester request slots (slot i at [W*i +: W])
//   s_addr_ok, s_data_ok    one-hot acks, only to the current owner
//   s_rdata                 shared read data, valid with s_data_ok
//   m_*                     single master-side sram-like port
//
// Configuration: ARB_ROUND_ROBIN_EN selects round-robin arbitration; when
//   undefined, lowest index wins and no rotation pointer exists.

module sram_like_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 64,
  parameter int DW   = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      s_req,
  input  logic [NREQ-1:0]      s_wr,
  input  logic [3*NREQ-1:0]    s_size,
  input  logic [AW*NREQ-1:0]   s_addr,
  input  logic [DW*NREQ-1:0]   s_wdata,
  output logic [NREQ-1:0]      s_addr_ok,
  output logic [NREQ-1:0]      s_data_ok,
  output logic [DW-1:0]        s_rdata,
  output logic                 m_req,
  output logic                 m_wr,
  output logic [2:0]           m_size,
  output logic [AW-1:0]        m_addr,
  output logic [DW-1:0]        m_wdata,
  input  logic                 m_addr_ok,
  input  logic                 m_data_ok,
  input  logic [DW-1:0]        m_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [2:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [IW-1:0]   rr_base;
  logic [IW-1:0]   scan_idx;
  logic            win_vld;
  logic [IW-1:0]   win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  assign rr_base = rr_ptr_q;
`else
  // Fixed priority is the round-robin scan anchored permanently at slot 0.
  assign rr_base = '0;
`endif

  // Scan requesters starting at rr_base, wrapping modulo NREQ; first hit wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IW'((int'(rr_base) + k) % NREQ);
      if (!win_vld && s_req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The winner's fields are captured here, so the requester may change
        // them after s_addr_ok without disturbing the master side.
        if (win_vld) begin
          state_d = ADDR;
          owner_d = win_idx;
          wr_d    = s_wr[win_idx];
          size_d  = s_size[int'(win_idx)*3 +: 3];
          addr_d  = s_addr[int'(win_idx)*AW +: AW];
          wdata_d = s_wdata[int'(win_idx)*DW +: DW];
        end
      end
      ADDR: begin
        if (m_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (m_data_ok) begin
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock) begin
    if (!resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Acks are gated by state, so stray master handshakes never reach anyone.
  always_comb begin
    s_addr_ok = '0;
    s_data_ok = '0;
    if ((state_q == ADDR) && m_addr_ok) s_addr_ok[owner_q] = 1'b1;
    if ((state_q == DATA) && m_data_ok) s_data_ok[owner_q] = 1'b1;
  end

  assign m_req   = (state_q == ADDR);
  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign s_rdata = m_rdata;

`ifndef SYNTHESIS
  // A data return with no transaction waiting for it points at a bridge bug.
  spurious_data_ok_a: assert property (@(posedge clock) disable iff (!resetn)
    !(m_data_ok && (state_q != DATA)))
    else $warning("m_data_ok outside DATA state, ignored");
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 64;
  localparam int DW   = 64;

  logic                clock;
  logic                resetn;
  logic [NREQ-1:0]     s_req;
  logic [NREQ-1:0]     s_wr;
  logic [3*NREQ-1:0]   s_size;
  logic [AW*NREQ-1:0]  s_addr;
  logic [DW*NREQ-1:0]  s_wdata;
  logic [NREQ-1:0]     s_addr_ok;
  logic [NREQ-1:0]     s_data_ok;
  logic [DW-1:0]       s_rdata;
  logic                m_req;
  logic                m_wr;
  logic [2:0]          m_size;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic                m_addr_ok;
  logic                m_data_ok;
  logic [DW-1:0]       m_rdata;

  sram_like_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .s_req     (s_req),
    .s_wr      (s_wr),
    .s_size    (s_size),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_addr_ok (s_addr_ok),
    .s_data_ok (s_data_ok),
    .s_rdata   (s_rdata),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_size    (m_size),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Transaction-level reference: one outstanding transaction record.
  bit          mb_busy  = 1'b0;   // a transaction is owned
  bit          mb_acc   = 1'b0;   // its address has been accepted
  int          mb_owner = 0;
  int          mb_rr    = 0;
  logic        mb_wr    = 1'b0;
  logic [2:0]  mb_size  = '0;
  logic [63:0] mb_addr  = '0;
  logic [63:0] mb_wdata = '0;
  int          n_done   = 0;

  function automatic int pick(input logic [NREQ-1:0] req, input int start);
    for (int k = 0; k < NREQ; k++)
      if (req[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      mb_busy <= 1'b0; mb_acc <= 1'b0; mb_owner <= 0; mb_rr <= 0;
      mb_wr <= 1'b0; mb_size <= '0; mb_addr <= '0; mb_wdata <= '0;
    end else if (!mb_busy) begin
      if (pick(s_req, mb_rr) >= 0) begin
        mb_busy  <= 1'b1;
        mb_owner <= pick(s_req, mb_rr);
        mb_wr    <= s_wr[pick(s_req, mb_rr)];
        mb_size  <= s_size[3*pick(s_req, mb_rr) +: 3];
        mb_addr  <= s_addr[64*pick(s_req, mb_rr) +: 64];
        mb_wdata <= s_wdata[64*pick(s_req, mb_rr) +: 64];
      end
    end else if (!mb_acc) begin
      if (m_addr_ok) mb_acc <= 1'b1;
    end else if (m_data_ok) begin
      mb_busy <= 1'b0;
      mb_acc  <= 1'b0;
      n_done  <= n_done + 1;
`ifdef ARB_ROUND_ROBIN_EN
      mb_rr   <= (mb_owner + 1) % NREQ;
`endif
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  logic [2:0] exp_aok, exp_dok;
  task automatic compare();
    exp_aok = (mb_busy && !mb_acc && m_addr_ok) ? (3'b001 << mb_owner) : 3'b000;
    exp_dok = (mb_busy &&  mb_acc && m_data_ok) ? (3'b001 << mb_owner) : 3'b000;
    chk("m_req",     m_req,     mb_busy && !mb_acc);
    chk("m_wr",      m_wr,      mb_wr);
    chk("m_size",    m_size,    mb_size);
    chk("m_addr",    m_addr,    mb_addr);
    chk("m_wdata",   m_wdata,   mb_wdata);
    chk("s_addr_ok", s_addr_ok, exp_aok);
    chk("s_data_ok", s_data_ok, exp_dok);
    chk("s_rdata",   s_rdata,   m_rdata);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [2:0] sz,
                         input logic [63:0] a, input logic [63:0] d);
    s_req[i]            = 1'b1;
    s_wr[i]             = wr;
    s_size[3*i +: 3]    = sz;
    s_addr[64*i +: 64]  = a;
    s_wdata[64*i +: 64] = d;
  endtask

  // Returns at 2 time units after the edge of the cycle carrying s_addr_ok.
  task automatic wait_addr_ok(output int who, output logic [2:0] aok);
    who = -1;
    aok = '0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (s_addr_ok != 0) begin
        aok = s_addr_ok;
        for (int b = 0; b < NREQ; b++) if (s_addr_ok[b]) who = b;
        break;
      end
      tick();
    end
    if (who < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL addr_ok_timeout: got none expected a pulse within 20 cycles");
    end
  endtask

  // Moves into DATA, returns m_data_ok, and leaves the bench in the next IDLE cycle.
  task automatic finish_data(input logic [63:0] rd, input logic [2:0] clr,
                             output logic [2:0] dok, output logic [63:0] rdat);
    tick();
    s_req     = s_req & ~clr;
    m_data_ok = 1'b1;
    m_rdata   = rd;
    #1;
    dok  = s_data_ok;
    rdat = s_rdata;
    tick();
    m_data_ok = 1'b0;
    m_rdata   = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          who;
  logic [2:0]  aok, dok, acked;
  logic [63:0] rdat;
  int          grants[3];
  int          exp_g[3];

  initial begin
    resetn = 1'b0; s_req = '0; s_wr = '0; s_size = '0; s_addr = '0; s_wdata = '0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2};
`else
    exp_g = '{0, 0, 0};
`endif
    fork
      forever begin
        @(negedge clock);
        if (chk_en) compare();
      end
      begin
        repeat (3) tick();
        #1;
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_s_addr_ok", s_addr_ok, 3'b000);
        chk("rst_s_data_ok", s_data_ok, 3'b000);
        chk("rst_m_addr", m_addr, 64'h0);
        chk("rst_m_wr", m_wr, 1'b0);
        chk("rst_m_size", m_size, 3'd0);
        chk("rst_m_wdata", m_wdata, 64'h0);
        chk_en = 1'b1;
        resetn = 1'b1;
        tick();

        // Single read from requester 0.
        set_req(0, 1'b0, 3'd2, 64'h0000_0000_8000_0000, 64'h0);
        m_addr_ok = 1'b1;
        #1;
        chk("t1_idle_m_req", m_req, 1'b0);
        tick();
        wait_addr_ok(who, aok);
        chk("t1_m_req", m_req, 1'b1);
        chk("t1_m_addr", m_addr, 64'h0000_0000_8000_0000);
        chk("t1_m_wr", m_wr, 1'b0);
        chk("t1_s_addr_ok", aok, 3'b001);
        finish_data(64'h0000_0000_DEAD_BEEF, 3'b001, dok, rdat);
        chk("t1_s_data_ok", dok, 3'b001);
        chk("t1_s_rdata", rdat, 64'h0000_0000_DEAD_BEEF);

        // Write from requester 2.
        set_req(2, 1'b1, 3'd3, 64'h0000_0000_1000_0040, 64'h1122_3344_5566_7788);
        wait_addr_ok(who, aok);
        chk("t2_s_addr_ok", aok, 3'b100);
        chk("t2_m_wr", m_wr, 1'b1);
        chk("t2_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
        chk("t2_m_size", m_size, 3'd3);
        finish_data(64'h0, 3'b100, dok, rdat);
        chk("t2_s_data_ok", dok, 3'b100);

        // Contention: all three hold s_req across three transactions.
        set_req(0, 1'b0, 3'd1, 64'hA000, 64'h0);
        set_req(1, 1'b0, 3'd1, 64'hA100, 64'h0);
        set_req(2, 1'b0, 3'd1, 64'hA200, 64'h0);
        for (int t = 0; t < 3; t++) begin
          wait_addr_ok(who, aok);
          grants[t] = who;
          finish_data(64'h5A5A_0000 + 64'(t), 3'b000, dok, rdat);
        end
        s_req = '0;
        for (int t = 0; t < 3; t++) chk($sformatf("t3_grant%0d", t), 64'(grants[t]), 64'(exp_g[t]));

        // Address backpressure for five cycles.
        set_req(1, 1'b0, 3'd2, 64'h0000_0000_CAFE_0000, 64'h0);
        m_addr_ok = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
          #1;
          chk("t4_m_req", m_req, 1'b1);
          chk("t4_m_addr", m_addr, 64'h0000_0000_CAFE_0000);
          chk("t4_no_addr_ok", s_addr_ok, 3'b000);
          tick();
        end
        m_addr_ok = 1'b1;
        wait_addr_ok(who, aok);
        chk("t4_s_addr_ok", aok, 3'b010);
        finish_data(64'h0, 3'b010, dok, rdat);

        // Stray m_data_ok while idle.
        m_data_ok = 1'b1;
        m_rdata   = 64'h0BAD_0BAD;
        #1;
        chk("t5_no_data_ok", s_data_ok, 3'b000);
        tick();
        m_data_ok = 1'b0;
        m_rdata   = '0;
        #1;
        set_req(0, 1'b0, 3'd2, 64'hB000, 64'h0);
        tick();
        #1;
        chk("t5_still_idle_grant", m_req, 1'b1);
        wait_addr_ok(who, aok);
        finish_data(64'h0, 3'b001, dok, rdat);

        // Reset while in DATA.
        set_req(1, 1'b0, 3'd3, 64'h0000_0000_0000_C0C0, 64'h0);
        wait_addr_ok(who, aok);
        chk("t6_s_addr_ok", aok, 3'b010);
        tick();
        s_req[1] = 1'b0;
        resetn   = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("t6_m_req", m_req, 1'b0);
        chk("t6_s_addr_ok0", s_addr_ok, 3'b000);
        chk("t6_s_data_ok0", s_data_ok, 3'b000);
        chk("t6_m_addr0", m_addr, 64'h0);
        set_req(0, 1'b0, 3'd1, 64'hD000, 64'h0);
        set_req(1, 1'b0, 3'd1, 64'hD100, 64'h0);
        wait_addr_ok(who, aok);
        chk("t6_first_grant", aok, 3'b001);
        finish_data(64'h0, 3'b001, dok, rdat);
        wait_addr_ok(who, aok);
        chk("t6_second_grant", aok, 3'b010);
        finish_data(64'h0, 3'b010, dok, rdat);

        // Random traffic; the per-cycle compare checks everything.
        n_done = 0;
        for (int c = 0; c < 3000; c++) begin
          @(negedge clock);
          acked = s_addr_ok;
          tick();
          for (int i = 0; i < NREQ; i++) begin
            if (s_req[i] && acked[i]) s_req[i] = 1'b0;
            else if (!s_req[i] && $urandom_range(0, 2) == 0)
              set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                      {$urandom, $urandom}, {$urandom, $urandom});
          end
          m_addr_ok = ($urandom_range(0, 2) != 0);
          m_data_ok = mb_busy && mb_acc && ($urandom_range(0, 2) == 0);
          m_rdata   = {$urandom, $urandom};
          resetn    = ($urandom_range(0, 299) != 0);
        end
        resetn = 1'b1;
        #1;
        chk("rand_progress", 64'(n_done > 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join_any
  end

endmodule
